// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: receive-side raster timing recovery for HS/VS/RGB video.
// Measures line length and lines per frame, locks onto the expected timing,
// recovers active pixel coordinates and captures the colour at a probe pixel.
// Optional per-frame pixel checksum is built when VGA_FRAME_SUM_EN is defined;
// otherwise frame_sum is tied to zero.
module vga_sync_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int H_ACTIVE    = 640,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic [3:0]  red_in,
    input  logic [3:0]  green_in,
    input  logic [3:0]  blue_in,
    input  logic [11:0] probe_h,
    input  logic [11:0] probe_v,
    output logic        locked,
    output logic [11:0] h_pos,
    output logic [11:0] v_pos,
    output logic        active,
    output logic        sample_valid,
    output logic [11:0] sample_rgb,
    output logic [11:0] line_len,
    output logic [11:0] frame_lines,
    output logic [7:0]  err_count,
    output logic [15:0] frame_count,
    output logic [15:0] frame_sum
);

    localparam logic [11:0] H_TOTAL_W     = 12'(H_TOTAL);
    localparam logic [11:0] V_TOTAL_W     = 12'(V_TOTAL);
    localparam logic [11:0] H_START       = 12'(H_SYNC + H_BP);
    localparam logic [11:0] H_END         = 12'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [11:0] V_START       = 12'(V_SYNC + V_BP);
    localparam logic [11:0] V_END         = 12'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [11:0] TIMEOUT_TICKS = 12'(2 * H_TOTAL);
    localparam logic [7:0]  LOCK_W        = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} lockState_t;

    lockState_t  state;
    logic        hsReg, hsPrev, vsReg, vsPrev;
    logic [11:0] rgbReg;
    logic [11:0] hCnt, vRow, lineCnt;
    logic [7:0]  goodCnt;
    logic        captured;

    logic        hsFall, vsFall;
    logic [11:0] hCntInc, hNext, vRowInc, vRowNext, lineCntInc, lineCntNext;
    logic        lenBad, frameBad, timeout, timingBad;
    logic        inWindow, activeNext, probeHit;
    logic [11:0] hPosNext, vPosNext;
    logic [7:0]  errInc;

    // Edge detection, next counter values, timing checks and active window.
    // The counters tag the pixel held in rgbReg, so window and probe use the
    // post-update counter values together with the not-yet-shifted rgbReg.
    always_comb begin
        hsFall     = hsPrev & ~hsReg;
        vsFall     = vsPrev & ~vsReg;
        hCntInc    = (hCnt == '1) ? hCnt : hCnt + 12'd1;
        hNext      = hsFall ? '0 : hCntInc;
        vRowInc    = (vRow == '1) ? vRow : vRow + 12'd1;
        lineCntInc = (lineCnt == '1) ? lineCnt : lineCnt + 12'd1;
        vRowNext   = vRow;
        if (vsFall)
            vRowNext = '0;
        else if (hsFall)
            vRowNext = vRowInc;
        // An HS fall coincident with the VS fall opens the new frame's count.
        lineCntNext = lineCnt;
        if (vsFall)
            lineCntNext = hsFall ? 12'd1 : '0;
        else if (hsFall)
            lineCntNext = lineCntInc;
        lenBad     = hsFall && (hCntInc != H_TOTAL_W);
        frameBad   = vsFall && (lineCnt != V_TOTAL_W);
        timeout    = !hsFall && (hCntInc == TIMEOUT_TICKS);
        timingBad  = lenBad || frameBad || timeout;
        inWindow   = (hNext >= H_START) && (hNext < H_END) &&
                     (vRowNext >= V_START) && (vRowNext < V_END);
        activeNext = locked && inWindow;
        hPosNext   = activeNext ? hNext - H_START : '0;
        vPosNext   = activeNext ? vRowNext - V_START : '0;
        probeHit   = activeNext && (hPosNext == probe_h) && (vPosNext == probe_v);
        errInc     = (err_count == '1) ? err_count : err_count + 8'd1;
    end

    // Input registers, raster counters, probe capture and the lock FSM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= SEARCH;
            hsReg        <= 1'b1;
            hsPrev       <= 1'b1;
            vsReg        <= 1'b1;
            vsPrev       <= 1'b1;
            rgbReg       <= '0;
            hCnt         <= '0;
            vRow         <= '0;
            lineCnt      <= '0;
            goodCnt      <= '0;
            captured     <= 1'b0;
            locked       <= 1'b0;
            h_pos        <= '0;
            v_pos        <= '0;
            active       <= 1'b0;
            sample_valid <= 1'b0;
            sample_rgb   <= '0;
            line_len     <= '0;
            frame_lines  <= '0;
            err_count    <= '0;
            frame_count  <= '0;
        end else begin
            sample_valid <= 1'b0;
            if (pix_en) begin
                hsReg   <= hs_in;
                hsPrev  <= hsReg;
                vsReg   <= vs_in;
                vsPrev  <= vsReg;
                rgbReg  <= {red_in, green_in, blue_in};
                hCnt    <= hNext;
                vRow    <= vRowNext;
                lineCnt <= lineCntNext;
                active  <= activeNext;
                h_pos   <= hPosNext;
                v_pos   <= vPosNext;
                if (hsFall)
                    line_len <= hCntInc;
                if (vsFall)
                    frame_lines <= lineCnt;

                if (probeHit && (!captured || vsFall)) begin
                    sample_rgb   <= rgbReg;
                    sample_valid <= 1'b1;
                    captured     <= 1'b1;
                end else if (vsFall) begin
                    captured <= 1'b0;
                end

                case (state)
                    SEARCH: begin
                        if (vsFall) begin
                            state   <= ACQUIRE;
                            goodCnt <= '0;
                        end
                    end
                    ACQUIRE: begin
                        if (timingBad) begin
                            err_count <= errInc;
                            state     <= SEARCH;
                        end else if (vsFall) begin
                            goodCnt <= goodCnt + 8'd1;
                            if (goodCnt + 8'd1 >= LOCK_W) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (timingBad) begin
                            err_count <= errInc;
                            state     <= SEARCH;
                            locked    <= 1'b0;
                        end else if (vsFall) begin
                            frame_count <= frame_count + 16'd1;
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef VGA_FRAME_SUM_EN
    logic [15:0] sumAcc;

    // Per-frame checksum of active pixels, published at each VS fall while locked.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sumAcc    <= '0;
            frame_sum <= '0;
        end else if (pix_en) begin
            if (vsFall) begin
                if (locked)
                    frame_sum <= sumAcc;
                sumAcc <= activeNext ? {4'b0, rgbReg} : '0;
            end else if (activeNext) begin
                sumAcc <= sumAcc + {4'b0, rgbReg};
            end
        end
    end
`else
    assign frame_sum = '0;
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor: directed bench for vga_sync_monitor on a reduced
// 20x12 raster (12x8 active) with pix_en every 4th clk.
module tb_vga_sync_monitor;

    logic        clk = 1'b0;
    logic        rst, pix_en, hs_in, vs_in;
    logic [3:0]  red_in, green_in, blue_in;
    logic [11:0] probe_h, probe_v;
    logic        locked, active, sample_valid;
    logic [11:0] h_pos, v_pos, sample_rgb, line_len, frame_lines;
    logic [7:0]  err_count;
    logic [15:0] frame_count, frame_sum;

    always #5 clk = ~clk;

    vga_sync_monitor #(
        .H_TOTAL(20), .V_TOTAL(12), .H_SYNC(3), .H_BP(2), .H_ACTIVE(12),
        .V_SYNC(1), .V_BP(2), .V_ACTIVE(8), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hs_in(hs_in), .vs_in(vs_in),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .probe_h(probe_h), .probe_v(probe_v), .locked(locked), .h_pos(h_pos),
        .v_pos(v_pos), .active(active), .sample_valid(sample_valid),
        .sample_rgb(sample_rgb), .line_len(line_len), .frame_lines(frame_lines),
        .err_count(err_count), .frame_count(frame_count), .frame_sum(frame_sum)
    );

`ifdef VGA_FRAME_SUM_EN
    localparam int FSUM = 2747;  // 95 * 0x001 + 0xA5C
`else
    localparam int FSUM = 0;
`endif

    int checks = 0;
    int failures = 0;
    int tickNo = 0;
    int gH = 0, gV = 0, curLen = 20;
    int shortPending = 0, holdLeft = 0;
    int validCount = 0, lastValidT = -1;

    typedef struct {
        int t;
        int lck;
        int lineLen;
        int frameLines;
        int err;
        int fc;
        int act;
        int hpos;
        int vpos;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s @tick %0d: got %0d expected %0d", name, tickNo - 1, act, exp);
        end
    endtask

    // One pix_en tick: drive generator pixel, sample outputs, check pulse width.
    task automatic doTick();
        logic hsV, vsV, v1;
        logic [11:0] col;
        if (gH == 0) begin
            curLen = (shortPending != 0) ? 19 : 20;
            shortPending = 0;
        end
        hsV = (gH >= 3) || (holdLeft > 0);
        if (holdLeft > 0) holdLeft--;
        vsV = (gV >= 1);
        col = 12'h000;
        if (gH >= 5 && gH < 17 && gV >= 3 && gV < 11)
            col = (gH - 5 == 10 && gV - 3 == 5) ? 12'hA5C : 12'h001;
        @(negedge clk);
        pix_en = 1'b1; hs_in = hsV; vs_in = vsV;
        red_in = col[11:8]; green_in = col[7:4]; blue_in = col[3:0];
        @(negedge clk);
        pix_en = 1'b0;
        tickNo++;
        v1 = sample_valid;
        if (v1) begin
            validCount++;
            lastValidT = tickNo - 1;
        end
        @(negedge clk);
        if (v1) chk("pulse_width", int'(sample_valid), 0);
        @(negedge clk);
        gH++;
        if (gH == curLen) begin
            gH = 0;
            gV = (gV == 11) ? 0 : gV + 1;
        end
    endtask

    task automatic advanceTo(input int n);
        while (tickNo <= n) doTick();
    endtask

    initial begin
        tbl[0]  = '{21,  0, 20, 0,  0, 0, 0, 0,  0};
        tbl[1]  = '{241, 0, 20, 12, 0, 0, 0, 0,  0};
        tbl[2]  = '{306, 0, 20, 12, 0, 0, 0, 0,  0};
        tbl[3]  = '{481, 1, 20, 12, 0, 0, 0, 0,  0};
        tbl[4]  = '{545, 1, 20, 12, 0, 0, 0, 0,  0};
        tbl[5]  = '{546, 1, 20, 12, 0, 0, 1, 0,  0};
        tbl[6]  = '{557, 1, 20, 12, 0, 0, 1, 11, 0};
        tbl[7]  = '{558, 1, 20, 12, 0, 0, 0, 0,  0};
        tbl[8]  = '{697, 1, 20, 12, 0, 0, 1, 11, 7};
        tbl[9]  = '{717, 1, 20, 12, 0, 0, 0, 0,  0};
        tbl[10] = '{721, 1, 20, 12, 0, 1, 0, 0,  0};

        rst = 1'b0; pix_en = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
        red_in = '0; green_in = '0; blue_in = '0;
        probe_h = 12'd10; probe_v = 12'd5;
        repeat (3) @(negedge clk);
        chk("rst_locked", int'(locked), 0);
        chk("rst_line_len", int'(line_len), 0);
        chk("rst_err", int'(err_count), 0);
        chk("rst_frame_sum", int'(frame_sum), 0);
        rst = 1'b1;

        // Ideal timing: acquire, lock, active window boundaries
        for (int unsigned i = 0; i < 11; i++) begin
            advanceTo(tbl[i].t);
            chk("tbl_locked", int'(locked), tbl[i].lck);
            chk("tbl_line_len", int'(line_len), tbl[i].lineLen);
            chk("tbl_frame_lines", int'(frame_lines), tbl[i].frameLines);
            chk("tbl_err", int'(err_count), tbl[i].err);
            chk("tbl_frame_count", int'(frame_count), tbl[i].fc);
            chk("tbl_active", int'(active), tbl[i].act);
            chk("tbl_h_pos", int'(h_pos), tbl[i].hpos);
            chk("tbl_v_pos", int'(v_pos), tbl[i].vpos);
        end

        // Probe capture in the first locked frame, then frame checksum
        chk("probe_count", validCount, 1);
        chk("probe_tick", lastValidT, 656);
        chk("probe_rgb", int'(sample_rgb), 12'hA5C);
        chk("frame_sum_f2", int'(frame_sum), FSUM);

        // Probe just outside the active width never fires
        probe_h = 12'd12;
        advanceTo(961);
        chk("probe_outside", validCount, 1);
        chk("fc_961", int'(frame_count), 2);
        chk("frame_sum_f3", int'(frame_sum), FSUM);
        probe_h = 12'd10;
        advanceTo(1201);
        chk("probe_back", validCount, 2);
        chk("probe_tick2", lastValidT, 1136);
        chk("fc_1201", int'(frame_count), 3);

        // One 19-tick line while locked
        advanceTo(1290);
        shortPending = 1;
        advanceTo(1319);
        chk("short_pre_locked", int'(locked), 1);
        chk("short_pre_err", int'(err_count), 0);
        advanceTo(1320);
        chk("short_locked", int'(locked), 0);
        chk("short_err", int'(err_count), 1);
        chk("short_line_len", int'(line_len), 19);
        advanceTo(1919);
        chk("relock_pre", int'(locked), 0);
        advanceTo(1920);
        chk("relock", int'(locked), 1);
        chk("relock_err", int'(err_count), 1);
        chk("relock_fc", int'(frame_count), 3);

        // HS held high for 45 ticks: single timeout
        advanceTo(1978);
        holdLeft = 45;
        advanceTo(1999);
        chk("to_pre_locked", int'(locked), 1);
        chk("to_pre_err", int'(err_count), 1);
        advanceTo(2000);
        chk("to_locked", int'(locked), 0);
        chk("to_err", int'(err_count), 2);
        advanceTo(2040);
        chk("to_line_len", int'(line_len), 80);
        chk("to_err_once", int'(err_count), 2);
        advanceTo(2160);
        chk("to_frame_lines", int'(frame_lines), 9);
        advanceTo(2639);
        chk("to_relock_pre", int'(locked), 0);
        advanceTo(2640);
        chk("to_relock", int'(locked), 1);
        chk("to_relock_err", int'(err_count), 2);

        // One-clk reset mid-frame
        advanceTo(2700);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_locked", int'(locked), 0);
        chk("mrst_err", int'(err_count), 0);
        chk("mrst_fc", int'(frame_count), 0);
        chk("mrst_line_len", int'(line_len), 0);
        chk("mrst_frame_lines", int'(frame_lines), 0);
        chk("mrst_rgb", int'(sample_rgb), 0);
        chk("mrst_active", int'(active), 0);
        chk("mrst_frame_sum", int'(frame_sum), 0);
        rst = 1'b1;
        advanceTo(3120);
        chk("mrst_acq_locked", int'(locked), 0);
        chk("mrst_acq_lines", int'(frame_lines), 12);
        chk("mrst_acq_len", int'(line_len), 20);
        advanceTo(3359);
        chk("mrst_relock_pre", int'(locked), 0);
        advanceTo(3360);
        chk("mrst_relock", int'(locked), 1);
        chk("mrst_relock_err", int'(err_count), 0);
        advanceTo(3600);
        chk("mrst_fc_end", int'(frame_count), 1);
        chk("mrst_probe_count", validCount, 3);
        chk("mrst_probe_tick", lastValidT, 3535);
        chk("mrst_probe_rgb", int'(sample_rgb), 12'hA5C);
        chk("mrst_frame_sum", int'(frame_sum), FSUM);
        chk("end_err", int'(err_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side counterpart of the video controller: consumes HS/VS/RGB as the VGA output path emits them and recovers raster timing.
- Measures line length and lines per frame, and runs a lock state machine against the expected 640x480 timing.
- Recovers pixel coordinates and captures the colour at a programmable probe pixel.
- Used as a loopback checker on the board and as the self-checking monitor in display benches.

Parameters:
- H_TOTAL, 800, expected pix_en ticks per line
- V_TOTAL, 525, expected lines per frame
- H_SYNC, 96, HS low width in ticks
- H_BP, 48, ticks from HS rise to first active pixel
- H_ACTIVE, 640, active pixels per line
- V_SYNC, 2, VS low width in lines
- V_BP, 33, lines from VS rise to first active row
- V_ACTIVE, 480, active rows
- LOCK_FRAMES, 2, consecutive good frames required to lock

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- pix_en  in  1  pixel-rate tick (divided-clock strobe); all state advances only when high
- hs_in  in  1  horizontal sync, active-low
- vs_in  in  1  vertical sync, active-low
- red_in  in  4  pixel red
- green_in  in  4  pixel green
- blue_in  in  4  pixel blue
- probe_h  in  12  probe column
- probe_v  in  12  probe row
- locked  out  1  timing locked
- h_pos  out  12  active column (0 outside the active window)
- v_pos  out  12  active row (0 outside the active window)
- active  out  1  current tick is an active pixel
- sample_valid  out  1  one-clk pulse, probe pixel captured
- sample_rgb  out  12  {red,green,blue} at the probe pixel
- line_len  out  12  last measured line length in ticks
- frame_lines  out  12  last measured lines per frame
- err_count  out  8  timing errors, saturating at 255
- frame_count  out  16  frames seen while locked, wraps
- frame_sum  out  16  per-frame pixel checksum (optional feature)

Behaviour:
- Reset (rst=0 at a clk edge): all outputs 0, FSM in SEARCH, internal counters 0, input registers cleared with hs/vs history set to 1.
- Inputs are registered on pix_en ticks. Edge detection uses the registered value versus the previous registered value.
- Output latency: one clk after the pix_en tick on which the registered input is evaluated.
- h_cnt:
  - Cleared to 0 on an HS falling edge; otherwise +1 per tick, saturating at 4095.
  - On an HS falling edge, line_len <= h_cnt+1.
- Row counting:
  - v_row <= 0 on a VS falling edge.
  - On an HS falling edge without a VS fall, v_row <= v_row+1, saturating at 4095.
  - On a VS fall, frame_lines <= lines counted since the previous VS fall.
  - An HS fall coinciding with a VS fall counts into the new frame. A 525-line frame therefore reads 525 regardless of alignment.
- Active window:
  - active = locked AND h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) AND v_row in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
  - h_pos = h_cnt-(H_SYNC+H_BP) and v_pos = v_row-(V_SYNC+V_BP) when active, else 0.
- Lock FSM:
  - SEARCH: the first VS fall moves to ACQUIRE and clears good_cnt.
  - ACQUIRE:
    - Any line_len != H_TOTAL causes err_count+1 and a return to SEARCH on that tick.
    - At each VS fall, frame_lines == V_TOTAL gives good_cnt+1; otherwise err_count+1 and SEARCH.
    - When good_cnt reaches LOCK_FRAMES, move to LOCKED.
  - LOCKED:
    - locked = 1; frame_count+1 at each VS fall.
    - Any bad line_len or bad frame_lines causes err_count+1, locked=0 on the next clk, and a move to SEARCH.
  - Timeout: no HS fall for 2*H_TOTAL ticks in any state except SEARCH causes err_count+1 and SEARCH, counted once per loss.
- Probe capture:
  - When active and h_pos==probe_h and v_pos==probe_v, sample_rgb <= registered RGB and sample_valid pulses for exactly 1 clk.
  - At most one capture per frame.
  - A probe outside the active area never fires.
- Reset mid-frame: returns to SEARCH; lock is reacquired only after LOCK_FRAMES full frames following the next VS fall.
- pix_en low: state is frozen, and sample_valid stays a 1-clk pulse.

Optional Feature:
- Macro VGA_FRAME_SUM_EN.
- Defined: frame_sum accumulates the 12-bit {r,g,b} of every active pixel modulo 2^16. The total is latched to frame_sum on the VS fall and the accumulator is cleared. It updates only while locked.
- Undefined: frame_sum is tied to 0 and no accumulator is synthesized.

Test Plan:
- Drive ideal 800x525 timing with pix_en every 4th clk. Expect line_len=800, frame_lines=525, locked=1 after the 1st VS fall plus 2 frames, err_count=0.
- Shorten one line to 799 ticks while locked. Expect locked=0 on the next clk, err_count=1, and relock after 2 further good frames.
- Set probe_h=10, probe_v=20 with the pixel colour 0xA5C at that position. Expect one sample_valid pulse per frame with sample_rgb=0xA5C.
- Hold hs_in high for 1700 ticks while locked. Expect a timeout, err_count incremented by exactly 1, and the FSM in SEARCH.
- Assert rst low mid-frame for 1 clk. Expect all outputs 0 and lock regained only after 2 complete frames.
- With VGA_FRAME_SUM_EN and a constant colour 0x001, expect frame_sum=307200 mod 65536=0xB000. Without the macro, expect frame_sum=0.
